// File: rtl/fairness_arbiter.sv
// rtl/fairness_arbiter.sv - traffic-light style lane arbiter with ALLRED/GREEN/YELLOW phases and per-lane wait aging
// Optional starvation override enabled by defining FAIRNESS_AGING_EN.
module fairness_arbiter #(
  parameter int N_LANES       = 4,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int AGE_W         = 5,
  parameter int AGE_LIMIT     = 20
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [N_LANES-1:0]         Lanes,
  output logic [N_LANES-1:0]         Green,
  output logic [N_LANES-1:0]         Yellow,
  output logic [$clog2(N_LANES)-1:0] Served,
  output logic [N_LANES-1:0]         Starve
);

  localparam int SW     = $clog2(N_LANES);
  localparam int PH_MAX = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int CW     = $clog2(PH_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_TH  = AGE_W'(AGE_LIMIT);

  typedef enum logic [1:0] {
    s_allred,
    s_green,
    s_yellow
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [SW-1:0]      served_nxt;
  logic [SW-1:0]      winner;
  logic               entering;
  logic [AGE_W-1:0]   wait_q   [N_LANES];
  logic [AGE_W-1:0]   wait_nxt [N_LANES];
  logic [N_LANES-1:0] starve_nxt;
  logic [N_LANES-1:0] green_nxt;
  logic [N_LANES-1:0] yellow_nxt;

  // Fixed priority picks the highest requesting index; a starving lane (lowest index first) overrides it.
  always_comb begin
    winner = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (Lanes[i]) winner = SW'(i);
    end
`ifdef FAIRNESS_AGING_EN
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (Lanes[i] && Starve[i]) winner = SW'(i);
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    served_nxt = Served;
    entering   = 1'b0;
    case (state)
      s_allred: begin
        if (|Lanes) begin
          state_nxt  = s_green;
          cnt_nxt    = CW'(1);
          served_nxt = winner;
          entering   = 1'b1;
        end
      end
      s_green: begin
        if (cnt == CW'(GREEN_CYCLES) || !Lanes[Served]) begin
          state_nxt = s_yellow;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      s_yellow: begin
        if (cnt == CW'(YELLOW_CYCLES)) begin
          state_nxt = s_allred;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = s_allred;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Starve is derived from the next wait value so it always agrees with the counter it reports.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      wait_nxt[i] = wait_q[i];
      if (!Lanes[i] || (entering && winner == SW'(i))) begin
        wait_nxt[i] = '0;
      end else if (!Green[i] && wait_q[i] != AGE_MAX) begin
        wait_nxt[i] = wait_q[i] + AGE_W'(1);
      end
      starve_nxt[i] = (wait_nxt[i] >= AGE_TH);
    end
  end

  always_comb begin
    green_nxt  = '0;
    yellow_nxt = '0;
    if (state_nxt == s_green)  green_nxt  = N_LANES'(1) << served_nxt;
    if (state_nxt == s_yellow) yellow_nxt = N_LANES'(1) << served_nxt;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= s_allred;
      cnt    <= '0;
      Green  <= '0;
      Yellow <= '0;
      Served <= '0;
      Starve <= '0;
      for (int i = 0; i < N_LANES; i++) wait_q[i] <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      Green  <= green_nxt;
      Yellow <= yellow_nxt;
      Served <= served_nxt;
      Starve <= starve_nxt;
      for (int i = 0; i < N_LANES; i++) wait_q[i] <= wait_nxt[i];
    end
  end

endmodule

// File: tb/tb_fairness_arbiter.sv
// tb/tb_fairness_arbiter.sv - self-checking bench for fairness_arbiter with a phase-timeline reference model
module tb_fairness_arbiter;

  localparam int N   = 4;
  localparam int GC  = 8;
  localparam int YC  = 2;
  localparam int AW  = 5;
  localparam int LIM = 20;
  localparam int WMAX = (1 << AW) - 1;
`ifdef FAIRNESS_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic         Clock;
  logic         Reset;
  logic [N-1:0] Lanes;
  logic [N-1:0] Green;
  logic [N-1:0] Yellow;
  logic [1:0]   Served;
  logic [N-1:0] Starve;

  fairness_arbiter #(
    .N_LANES(N), .GREEN_CYCLES(GC), .YELLOW_CYCLES(YC), .AGE_W(AW), .AGE_LIMIT(LIM)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Lanes (Lanes),
    .Green (Green),
    .Yellow(Yellow),
    .Served(Served),
    .Starve(Starve)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=allred 1=green 2=yellow, with elapsed cycles and lane being served.
  int m_phase = 0;
  int m_elapsed = 0;
  int m_lane = 0;
  int m_wait [N];
  int e_green = 0, e_yellow = 0, e_served = 0, e_starve = 0;

  always @(posedge Clock) begin
    int win;
    bit sel;
    if (Reset) begin
      m_phase = 0; m_elapsed = 0; m_lane = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      e_green = 0; e_yellow = 0; e_served = 0; e_starve = 0;
    end else begin
      sel = 1'b0;
      win = 0;
      if (m_phase == 0 && Lanes != 0) begin
        sel = 1'b1;
        for (int i = N - 1; i >= 0; i--) if (Lanes[i]) begin win = i; break; end
        if (AGING) begin
          for (int i = 0; i < N; i++)
            if (Lanes[i] && m_wait[i] >= LIM) begin win = i; break; end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!Lanes[i] || (sel && win == i)) m_wait[i] = 0;
        else if (!e_green[i] && m_wait[i] < WMAX) m_wait[i] = m_wait[i] + 1;
      end
      case (m_phase)
        0: if (sel) begin m_phase = 1; m_elapsed = 1; m_lane = win; end
        1: if (m_elapsed >= GC || !Lanes[m_lane]) begin m_phase = 2; m_elapsed = 1; end
           else m_elapsed++;
        default: if (m_elapsed >= YC) begin m_phase = 0; m_elapsed = 0; end
                 else m_elapsed++;
      endcase
      e_green  = (m_phase == 1) ? (1 << m_lane) : 0;
      e_yellow = (m_phase == 2) ? (1 << m_lane) : 0;
      e_served = m_lane;
      e_starve = 0;
      for (int i = 0; i < N; i++) if (m_wait[i] >= LIM) e_starve |= (1 << i);
    end
  end

  always @(negedge Clock) begin
    if (check_en) begin
      chk("model_green",  int'(Green),  e_green);
      chk("model_yellow", int'(Yellow), e_yellow);
      chk("model_served", int'(Served), e_served);
      chk("model_starve", int'(Starve), e_starve);
      chk("green_yellow_excl", int'((|Green) && (|Yellow)), 0);
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      @(negedge Clock);
    end
  endtask

  // Leaves Reset high at a negedge; the caller releases it, making the current cycle cycle 0.
  task automatic do_reset();
    Reset = 1'b1;
    Lanes = '0;
    step(2);
  endtask

  logic [N-1:0] vec [16] = '{4'b0001, 4'b0011, 4'b0110, 4'b1000, 4'b0000, 4'b1111, 4'b0101, 4'b1010,
                             4'b0100, 4'b0010, 4'b1001, 4'b0000, 4'b1100, 4'b0111, 4'b0001, 4'b1110};

  initial begin
    Reset = 1'b1;
    Lanes = '0;
    step(1);
    check_en = 1'b1;

    do_reset();
    chk("rst_green",  int'(Green),  0);
    chk("rst_yellow", int'(Yellow), 0);
    chk("rst_served", int'(Served), 0);
    chk("rst_starve", int'(Starve), 0);
    Reset = 1'b0;
    step(20);
    chk("idle_green",  int'(Green),  0);
    chk("idle_starve", int'(Starve), 0);

    do_reset();
    Lanes = 4'b0100; Reset = 1'b0;
    step(1);  chk("hold_c1_green",  int'(Green), 4'b0100);
    chk("hold_c1_served", int'(Served), 2);
    step(7);  chk("hold_c8_green",  int'(Green), 4'b0100);
    step(1);  chk("hold_c9_yellow", int'(Yellow), 4'b0100);
    chk("hold_c9_green", int'(Green), 0);
    step(1);  chk("hold_c10_yellow", int'(Yellow), 4'b0100);
    step(1);  chk("hold_c11_allred", int'(Green | Yellow), 0);
    step(1);  chk("hold_c12_green", int'(Green), 4'b0100);

    do_reset();
    Lanes = 4'b0010; Reset = 1'b0;
    step(3);  chk("drop_c3_green", int'(Green), 4'b0010);
    Lanes = 4'b0000;
    step(1);  chk("drop_c4_yellow", int'(Yellow), 4'b0010);
    step(1);  chk("drop_c5_yellow", int'(Yellow), 4'b0010);
    step(1);  chk("drop_c6_allred", int'(Green | Yellow), 0);
    chk("drop_c6_served", int'(Served), 1);

    do_reset();
    Lanes = 4'b1001; Reset = 1'b0;
    step(12); chk("age_c12_green", int'(Green), 4'b1000);
    step(7);  chk("age_c19_starve0", int'(Starve[0]), 0);
    step(1);  chk("age_c20_starve0", int'(Starve[0]), 1);
    step(2);  chk("age_c22_allred", int'(Green), 0);
    step(1);  chk("age_c23_green", int'(Green), AGING ? 4'b0001 : 4'b1000);
    chk("age_c23_starve0", int'(Starve[0]), AGING ? 0 : 1);
    step(22); chk("age_c45_starve", int'(Starve), AGING ? 0 : 4'b0001);
    if (!AGING) chk("age_c45_green", int'(Green), 4'b1000);

    do_reset();
    Lanes = 4'b1000; Reset = 1'b0;
    step(5);  chk("abort_c5_green", int'(Green), 4'b1000);
    chk("abort_c5_served", int'(Served), 3);
    Reset = 1'b1;
    step(1);
    chk("abort_green",  int'(Green),  0);
    chk("abort_yellow", int'(Yellow), 0);
    chk("abort_served", int'(Served), 0);
    chk("abort_starve", int'(Starve), 0);
    Reset = 1'b0;
    step(1);  chk("abort_restart_green", int'(Green), 4'b1000);

    do_reset();
    Reset = 1'b0;
    for (int v = 0; v < 16; v++) begin
      Lanes = vec[v];
      step(3);
    end
    Lanes = 4'b0001;
    step(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fairness_arbiter.md
FAIRNESS_ARBITER -- requirements
Module: fairness_arbiter

Interface
REQ-001 SHALL have parameter N_LANES, default 4; number of lanes, legal range 2..16.
REQ-002 SHALL have parameter GREEN_CYCLES, default 8; maximum green length in cycles, minimum 1.
REQ-003 SHALL have parameter YELLOW_CYCLES, default 2; yellow length in cycles, minimum 1.
REQ-004 SHALL have parameter AGE_W, default 5; wait-counter width in bits.
REQ-005 SHALL have parameter AGE_LIMIT, default 20; starvation threshold, at most 2^AGE_W-1.
REQ-006 SHALL have port Clock, input, 1 bit; single clock, rising edge.
REQ-007 SHALL have port Reset, input, 1 bit; synchronous, active-high.
REQ-008 SHALL have port Lanes, input, N_LANES bits; per-lane vehicle-present request, level sensitive.
REQ-009 SHALL have port Green, output, N_LANES bits; one-hot or zero green indication.
REQ-010 SHALL have port Yellow, output, N_LANES bits; one-hot or zero yellow indication.
REQ-011 SHALL have port Served, output, clog2(N_LANES) bits; index of the lane in GREEN/YELLOW, else last served.
REQ-012 SHALL have port Starve, output, N_LANES bits; per-lane wait counter >= AGE_LIMIT.

Function
REQ-013 SHALL implement states ALLRED, GREEN and YELLOW; all outputs SHALL be registered.
REQ-014 In ALLRED, Green and Yellow SHALL be zero; if any Lanes bit is set, the FSM SHALL latch the winner and enter GREEN on the next cycle; otherwise it SHALL stay in ALLRED.
REQ-015 Winner selection SHALL use Lanes and wait counters as sampled in the ALLRED cycle.
REQ-016 Base winner SHALL be the highest-index requesting lane (fixed priority).
REQ-017 In GREEN, Green[Served] SHALL be 1; a cycle counter SHALL count from 1.
REQ-018 GREEN SHALL exit to YELLOW after GREEN_CYCLES cycles, or earlier at the first GREEN cycle in which Lanes[Served] is 0.
REQ-019 YELLOW SHALL assert only Yellow[Served] for exactly YELLOW_CYCLES cycles, then enter ALLRED.
REQ-020 Every transition between two greens SHALL include at least one ALLRED cycle; Green and Yellow SHALL never be set together.
REQ-021 Per-lane wait counter SHALL increment each cycle in which the lane requests and its Green bit is 0.
REQ-022 The wait counter SHALL saturate at 2^AGE_W-1 with no wrap-around.
REQ-023 The wait counter SHALL clear when its lane enters GREEN or when its request is 0; clearing SHALL win over incrementing.
REQ-024 Starve[i] SHALL equal (wait[i] >= AGE_LIMIT), registered.
REQ-025 Requests SHALL NOT be latched; a lane that drops during ALLRED before selection SHALL be ignored.

Reset
REQ-026 On Reset=1 at a clock edge, the state SHALL become ALLRED, with Green=0, Yellow=0, Served=0, Starve=0 and all wait and phase counters 0.
REQ-027 Reset mid-GREEN or mid-YELLOW SHALL abort the phase immediately, with no yellow completion.
REQ-028 The first selection SHALL occur in the first cycle after Reset deasserts.

Configuration
REQ-029 With macro FAIRNESS_AGING_EN defined, any starving lane SHALL override the base winner; among starving lanes the lowest index SHALL win.
REQ-030 Without FAIRNESS_AGING_EN, selection SHALL be pure fixed priority; wait counters and Starve SHALL still operate and report.

Verification
REQ-031 Defaults, Lanes=0 after reset for 20 cycles -> Green=0, Yellow=0, state ALLRED, Starve=0 throughout.
REQ-032 Lanes=4'b0100 held from cycle 0 -> Green=0100 for cycles 1-8, Yellow=0100 for cycles 9-10, ALLRED at cycle 11, Green=0100 again from cycle 12.
REQ-033 Lanes=4'b0010, bit 1 dropped at cycle 3 -> Green ends after cycle 3, Yellow=0010 for cycles 4-5, ALLRED at cycle 6.
REQ-034 Lanes=4'b1001 held, FAIRNESS_AGING_EN defined -> lane 3 green for cycles 1-8 and 12-19; Starve[0]=1 by cycle 22; Green=0001 from cycle 23; wait[0] cleared at cycle 23.
REQ-035 Same stimulus without FAIRNESS_AGING_EN -> lane 3 wins every selection; Starve[0]=1 and wait[0] saturates at 31.
REQ-036 Reset asserted at cycle 5 of a green -> next cycle Green=0, Yellow=0, Served=0, all counters 0.
